// File: rtl/mux_nto1_stream.sv
// N-input registered stream multiplexer with fixed-select or round-robin grant.
// Define MUX_NTO1_STREAM_ID_EN to add the out_id port carrying the source channel index.
module mux_nto1_stream #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*W-1:0]     in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [$clog2(N)-1:0] sel,
  input  logic               mode,
  output logic [W-1:0]       out_data,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX_NTO1_STREAM_ID_EN
  ,
  output logic [$clog2(N)-1:0] out_id
`endif
);

  localparam int SW = $clog2(N);

  logic [W-1:0]  r_data_p1;
  logic          r_vld_p1;
  logic [SW-1:0] r_rr_ptr;
`ifdef MUX_NTO1_STREAM_ID_EN
  logic [SW-1:0] r_id_p1;
`endif

  logic          w_load_en;
  logic          w_grant_vld;
  logic [SW-1:0] w_grant;
  logic [W-1:0]  w_sel_data;
  logic [N-1:0]  w_ready;
  logic          w_xfer;

  assign w_load_en = !r_vld_p1 || out_ready;

  // Fixed mode matches sel against real channel indices only, so sel>=N never grants.
  always_comb begin
    int idx;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    idx         = 0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SW'(i) && in_valid[i]) begin
          w_grant_vld = 1'b1;
          w_grant     = SW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(r_rr_ptr) + k) % N;
        for (int i = 0; i < N; i++) begin
          if (i == idx && in_valid[i] && !w_grant_vld) begin
            w_grant_vld = 1'b1;
            w_grant     = SW'(i);
          end
        end
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    w_ready    = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SW'(i)) begin
        w_sel_data = in_data[i*W +: W];
        w_ready[i] = w_load_en && w_grant_vld;
      end
    end
  end

  assign w_xfer   = w_load_en && w_grant_vld;
  assign in_ready = w_ready;

  // p0 -> p1: output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_rr_ptr  <= SW'(N - 1);
`ifdef MUX_NTO1_STREAM_ID_EN
      r_id_p1   <= '0;
`endif
    end else if (w_xfer) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= w_sel_data;
`ifdef MUX_NTO1_STREAM_ID_EN
      r_id_p1   <= w_grant;
`endif
      if (mode) r_rr_ptr <= w_grant;
    end else if (out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_data  = r_data_p1;
  assign out_valid = r_vld_p1;
`ifdef MUX_NTO1_STREAM_ID_EN
  assign out_id    = r_id_p1;
`endif

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench for mux_nto1_stream: a 4-channel instance plus a 3-channel instance
// for the sel>=N boundary; works with or without MUX_NTO1_STREAM_ID_EN.
module tb_mux_nto1_stream;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic        mode3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;

`ifdef MUX_NTO1_STREAM_ID_EN
  logic [1:0]  out_id;
  logic [1:0]  out_id3;
`endif

  int checks = 0;
  int errors = 0;

  mux_nto1_stream #(.N(4), .W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_NTO1_STREAM_ID_EN
    , .out_id(out_id)
`endif
  );

  mux_nto1_stream #(.N(3), .W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef MUX_NTO1_STREAM_ID_EN
    , .out_id(out_id3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic [1:0] exp);
`ifdef MUX_NTO1_STREAM_ID_EN
    chk(tag, {30'd0, out_id}, {30'd0, exp});
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] d [4];
  logic [1:0] rr_exp [8];
  logic [7:0] sb_exp [6];

  initial begin
    d[0] = 8'hA0; d[1] = 8'hB1; d[2] = 8'hC2; d[3] = 8'hD3;
    rst_n = 1'b0; in_data = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b0;
    in_data3 = '0; in_valid3 = '0; sel3 = '0; mode3 = 1'b0; out_ready3 = 1'b0;
    repeat (2) tick();

    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    chk("rst_out_valid3", {31'd0, out_valid3}, 32'd0);
    chk_id("rst_out_id", 2'd0);
    rst_n = 1'b1;

    // Fixed mode, sel=2 with every channel valid
    mode = 1'b0; sel = 2'd2; in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    in_valid = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    chk("fix_in_ready_sel2", {28'd0, in_ready}, 32'h4);
    tick();
    chk("fix_out_valid", {31'd0, out_valid}, 32'd1);
    chk("fix_out_data_sel2", {24'd0, out_data}, 32'hA5);
    chk_id("fix_id_sel2", 2'd2);
    sel = 2'd1;
    @(negedge clk);
    chk("fix_in_ready_sel1", {28'd0, in_ready}, 32'h2);
    tick();
    chk("fix_out_data_sel1", {24'd0, out_data}, 32'h22);
    chk_id("fix_id_sel1", 2'd1);

    // Asynchronous reset while a beat is held
    in_valid = 4'b0000; out_ready = 1'b0;
    #2;
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_out_data", {24'd0, out_data}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Round-robin over all four channels, first grant goes to channel 0
    in_data = {d[3], d[2], d[1], d[0]};
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rr_in_ready_%0d", k), {28'd0, in_ready}, 32'd1 << (k % 4));
      tick();
      chk($sformatf("rr_out_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("rr_out_data_%0d", k), {24'd0, out_data}, {24'd0, d[k % 4]});
      chk_id($sformatf("rr_id_%0d", k), 2'(k % 4));
    end

    // Sparse valid 1010 alternates grants 1 and 3
    in_valid = 4'b1010;
    rr_exp[0] = 2'd1; rr_exp[1] = 2'd3; rr_exp[2] = 2'd1; rr_exp[3] = 2'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr_sparse_ready_%0d", k), {28'd0, in_ready}, 32'd1 << rr_exp[k]);
      tick();
      chk($sformatf("rr_sparse_data_%0d", k), {24'd0, out_data}, {24'd0, d[rr_exp[k]]});
      chk_id($sformatf("rr_sparse_id_%0d", k), rr_exp[k]);
    end

    // Backpressure: held beat from channel 3, no ready offered
    in_valid = 4'b1111; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready_%0d", k), {28'd0, in_ready}, 32'd0);
      chk($sformatf("bp_out_data_%0d", k), {24'd0, out_data}, {24'd0, d[3]});
      chk($sformatf("bp_out_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {28'd0, in_ready}, 32'h1);
    tick();
    chk("bp_release_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_release_data", {24'd0, out_data}, {24'd0, d[0]});

    // Pop without a load empties the register and keeps data
    in_valid = 4'b0000;
    tick();
    chk("pop_out_valid", {31'd0, out_valid}, 32'd0);
    chk("pop_out_data_hold", {24'd0, out_data}, {24'd0, d[0]});

    // N=3 boundary: sel=3 never grants
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    in_data3 = {8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("n3_sel3_ready_%0d", k), {29'd0, in_ready3}, 32'd0);
      tick();
      chk($sformatf("n3_sel3_valid_%0d", k), {31'd0, out_valid3}, 32'd0);
    end
    sel3 = 2'd2;
    @(negedge clk);
    chk("n3_sel2_ready", {29'd0, in_ready3}, 32'h4);
    tick();
    chk("n3_sel2_data", {24'd0, out_data3}, 32'h33);
    chk("n3_sel2_valid", {31'd0, out_valid3}, 32'd1);

    // Mode switch mid-stream: fixed ch2 x2, rr (ptr still 0) 1,2,3, fixed ch0
    sb_exp[0] = d[2]; sb_exp[1] = d[2]; sb_exp[2] = d[1];
    sb_exp[3] = d[2]; sb_exp[4] = d[3]; sb_exp[5] = d[0];
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mode = (k >= 2 && k <= 4);
      sel  = (k == 5) ? 2'd0 : 2'd2;
      tick();
      chk($sformatf("sw_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("sw_data_%0d", k), {24'd0, out_data}, {24'd0, sb_exp[k]});
    end
    in_valid = 4'b0000;
    tick();
    chk("sw_drain_valid", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
